// File: rtl/pulse_sched_pkg.sv
// Shared types and default sizing for the pulse scheduler channels.
package pulse_sched_pkg;

    localparam int unsigned DEF_NUM_CH = 4;
    localparam int unsigned DEF_CNT_W  = 6;

    // Per-channel lifecycle: waiting for a valid config, counting ticks, or spent (one-shot).
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } ch_state_e;

endpackage

// File: rtl/pulse_sched_channel.sv
// One pulse channel: counts unpaused time-base ticks and fires a registered
// one-cycle pulse when the count reaches the programmed period.
module pulse_sched_channel
    import pulse_sched_pkg::*;
#(
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tick_i,
    input  logic             pause_i,
    input  logic             en_i,
    input  logic             restart_i,
    input  logic             one_shot_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             pulse_o,
    output logic             active_o
);

    ch_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pulse_q, pulse_d;

    logic             cfg_ok;
    logic             at_end;

    // A zero period is treated the same as a disabled channel.
    assign cfg_ok = en_i && (period_i != '0);

    // '>=' rather than '==' so a period lowered below the running count fires on the next
    // tick instead of wrapping. Only consulted when period_i is nonzero, so no underflow.
    assign at_end = (cnt_q >= (period_i - CNT_W'(1)));

    // Next-state: disable beats restart, restart beats pause and tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;

        if (!cfg_ok) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (restart_i) begin
            state_d = COUNT;
            cnt_d   = '0;
        end else if (!pause_i) begin
            case (state_q)
                IDLE: begin
                    state_d = COUNT;
                    cnt_d   = '0;
                end
                COUNT: begin
                    if (tick_i) begin
                        if (at_end) begin
                            pulse_d = 1'b1;
                            cnt_d   = '0;
                            if (one_shot_i) begin
                                state_d = DONE;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and pulse registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_o  = pulse_q;
    assign active_o = (state_q == COUNT);

endmodule

// File: rtl/spawn_pulse_scheduler.sv
// Bank of independent pulse channels sharing one time-base tick and a global pause.
module spawn_pulse_scheduler
    import pulse_sched_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    resetN,
    input  logic                    oneSecPulse,
    input  logic                    pause,
    input  logic [NUM_CH-1:0]       chan_en,
    input  logic [NUM_CH-1:0]       restart,
    input  logic [NUM_CH-1:0]       one_shot,
    input  logic [NUM_CH*CNT_W-1:0] period,
    output logic [NUM_CH-1:0]       pulse,
    output logic [NUM_CH-1:0]       active
);

    // Channel c takes its period from bits [c*CNT_W +: CNT_W].
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pulse_sched_channel #(
            .CNT_W(CNT_W)
        ) u_ch (
            .clk_i      (clk),
            .rst_ni     (resetN),
            .tick_i     (oneSecPulse),
            .pause_i    (pause),
            .en_i       (chan_en[g]),
            .restart_i  (restart[g]),
            .one_shot_i (one_shot[g]),
            .period_i   (period[g*CNT_W +: CNT_W]),
            .pulse_o    (pulse[g]),
            .active_o   (active[g])
        );
    end

endmodule

// File: tb/tb_spawn_pulse_scheduler.sv
// Self-checking bench for spawn_pulse_scheduler: directed scenarios plus random traffic,
// all checked cycle by cycle against a behavioural tick-counting model.
module tb_spawn_pulse_scheduler;

    localparam int NCH = 4;
    localparam int CW  = 6;

    logic              clk;
    logic              resetN;
    logic              oneSecPulse;
    logic              pause;
    logic [NCH-1:0]    chan_en;
    logic [NCH-1:0]    restart;
    logic [NCH-1:0]    one_shot;
    logic [NCH*CW-1:0] period;
    logic [NCH-1:0]    pulse;
    logic [NCH-1:0]    active;

    int n_cmp;
    int n_mis;

    // Reference model: whether a channel is counting, whether a one-shot has been spent,
    // how many ticks have accumulated, and what the pulse output should be.
    bit             m_counting [NCH];
    bit             m_spent    [NCH];
    int             m_ticks    [NCH];
    logic [NCH-1:0] m_pulse;
    logic [NCH-1:0] m_active;

    spawn_pulse_scheduler #(
        .NUM_CH(NCH),
        .CNT_W (CW)
    ) dut (
        .clk        (clk),
        .resetN     (resetN),
        .oneSecPulse(oneSecPulse),
        .pause      (pause),
        .chan_en    (chan_en),
        .restart    (restart),
        .one_shot   (one_shot),
        .period     (period),
        .pulse      (pulse),
        .active     (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_counting[c] = 1'b0;
            m_spent[c]    = 1'b0;
            m_ticks[c]    = 0;
        end
        m_pulse  = '0;
        m_active = '0;
    endtask

    // Applies one clock edge worth of rules to the model, using the inputs held at that edge.
    task automatic model_step();
        for (int c = 0; c < NCH; c++) begin
            int per;
            per        = int'(period[c*CW +: CW]);
            m_pulse[c] = 1'b0;
            if (chan_en[c] !== 1'b1 || per == 0) begin
                m_counting[c] = 1'b0;
                m_spent[c]    = 1'b0;
                m_ticks[c]    = 0;
            end else if (restart[c]) begin
                m_counting[c] = 1'b1;
                m_spent[c]    = 1'b0;
                m_ticks[c]    = 0;
            end else if (!pause) begin
                if (!m_counting[c] && !m_spent[c]) begin
                    m_counting[c] = 1'b1;
                    m_ticks[c]    = 0;
                end else if (m_counting[c] && oneSecPulse) begin
                    if (m_ticks[c] + 1 >= per) begin
                        m_pulse[c] = 1'b1;
                        m_ticks[c] = 0;
                        if (one_shot[c]) begin
                            m_counting[c] = 1'b0;
                            m_spent[c]    = 1'b1;
                        end
                    end else begin
                        m_ticks[c] = m_ticks[c] + 1;
                    end
                end
            end
        end
        for (int c = 0; c < NCH; c++) m_active[c] = m_counting[c];
    endtask

    // One clock: the DUT and model both consume the current inputs; returns 1ns after the edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_period(input int c, input int v);
        period[c*CW +: CW] = CW'(v);
    endtask

    // Drops every channel so the next scenario starts from a clean count.
    task automatic clear_all();
        oneSecPulse = 1'b0;
        pause       = 1'b0;
        restart     = '0;
        chan_en     = '0;
        one_shot    = '0;
        period      = '0;
        cycle();
    endtask

    task automatic test_reset();
        resetN      = 1'b0;
        oneSecPulse = 1'b1;
        pause       = 1'b0;
        chan_en     = '1;
        restart     = '0;
        one_shot    = '0;
        for (int c = 0; c < NCH; c++) set_period(c, 1);
        model_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (pulse !== 4'b0000) begin
                n_mis++;
                $display("FAIL reset.pulse cyc=%0d got=%b want=0000", i, pulse);
            end
            n_cmp++;
            if (active !== 4'b0000) begin
                n_mis++;
                $display("FAIL reset.active cyc=%0d got=%b want=0000", i, active);
            end
        end
        oneSecPulse = 1'b0;
        chan_en     = '0;
        period      = '0;
        #3 resetN   = 1'b1;
        cycle();
    endtask

    task automatic test_periodic();
        int seen;
        clear_all();
        chan_en[0] = 1'b1;
        set_period(0, 2);
        cycle();
        seen = 0;
        for (int k = 1; k <= 6; k++) begin
            oneSecPulse = 1'b1;
            cycle();
            n_cmp++;
            if (pulse !== m_pulse || active !== m_active) begin
                n_mis++;
                $display("FAIL periodic.model tick=%0d got p=%b a=%b want p=%b a=%b",
                         k, pulse, active, m_pulse, m_active);
            end
            n_cmp++;
            if (pulse[0] !== (k % 2 == 0)) begin
                n_mis++;
                $display("FAIL periodic.fire tick=%0d got=%b want=%0d", k, pulse[0], k % 2 == 0);
            end
            if (pulse[0] === 1'b1) seen++;
            oneSecPulse = 1'b0;
            cycle();
            if (pulse[0] === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 3) begin
            n_mis++;
            $display("FAIL periodic.count got=%0d want=3", seen);
        end
    endtask

    task automatic test_one_shot();
        int seen;
        clear_all();
        chan_en[1]  = 1'b1;
        one_shot[1] = 1'b1;
        set_period(1, 3);
        cycle();
        seen = 0;
        for (int k = 1; k <= 9; k++) begin
            oneSecPulse = 1'b1;
            cycle();
            n_cmp++;
            if (pulse[1] !== (k == 3)) begin
                n_mis++;
                $display("FAIL one_shot.fire tick=%0d got=%b want=%0d", k, pulse[1], k == 3);
            end
            if (pulse[1] === 1'b1) seen++;
            oneSecPulse = 1'b0;
            cycle();
        end
        n_cmp++;
        if (seen != 1 || active[1] !== 1'b0) begin
            n_mis++;
            $display("FAIL one_shot.spent got count=%0d active=%b want count=1 active=0",
                     seen, active[1]);
        end
        restart[1] = 1'b1;
        cycle();
        restart[1] = 1'b0;
        n_cmp++;
        if (active[1] !== 1'b1 || pulse[1] !== 1'b0) begin
            n_mis++;
            $display("FAIL one_shot.restart got a=%b p=%b want a=1 p=0", active[1], pulse[1]);
        end
        for (int k = 1; k <= 3; k++) begin
            oneSecPulse = 1'b1;
            cycle();
            n_cmp++;
            if (pulse[1] !== (k == 3) || pulse !== m_pulse) begin
                n_mis++;
                $display("FAIL one_shot.refire tick=%0d got=%b want=%0d model=%b",
                         k, pulse[1], k == 3, m_pulse);
            end
            oneSecPulse = 1'b0;
            cycle();
        end
    endtask

    task automatic test_pause();
        int seen;
        clear_all();
        chan_en[0] = 1'b1;
        set_period(0, 4);
        cycle();
        seen = 0;
        for (int k = 1; k <= 9; k++) begin
            pause       = (k >= 3 && k <= 7);
            oneSecPulse = 1'b1;
            cycle();
            n_cmp++;
            if (pulse[0] !== (k == 9) || pulse !== m_pulse || active !== m_active) begin
                n_mis++;
                $display("FAIL pause.tick tick=%0d got p=%b a=%b want p0=%0d model p=%b a=%b",
                         k, pulse, active, k == 9, m_pulse, m_active);
            end
            if (pulse[0] === 1'b1) seen++;
            oneSecPulse = 1'b0;
            cycle();
        end
        pause = 1'b0;
        n_cmp++;
        if (seen != 1) begin
            n_mis++;
            $display("FAIL pause.count got=%0d want=1", seen);
        end
    endtask

    task automatic test_restart_vs_tick();
        clear_all();
        chan_en[2] = 1'b1;
        set_period(2, 2);
        cycle();
        oneSecPulse = 1'b1;
        cycle();
        oneSecPulse = 1'b0;
        cycle();
        oneSecPulse = 1'b1;
        restart[2]  = 1'b1;
        cycle();
        restart[2]  = 1'b0;
        n_cmp++;
        if (pulse[2] !== 1'b0) begin
            n_mis++;
            $display("FAIL restart_tick.collide got=%b want=0", pulse[2]);
        end
        oneSecPulse = 1'b0;
        cycle();
        for (int k = 1; k <= 2; k++) begin
            oneSecPulse = 1'b1;
            cycle();
            n_cmp++;
            if (pulse[2] !== (k == 2) || pulse !== m_pulse) begin
                n_mis++;
                $display("FAIL restart_tick.after tick=%0d got=%b want=%0d", k, pulse[2], k == 2);
            end
            oneSecPulse = 1'b0;
            cycle();
        end
    endtask

    task automatic test_shrink_and_reset();
        clear_all();
        chan_en[3] = 1'b1;
        set_period(3, 8);
        cycle();
        for (int k = 1; k <= 5; k++) begin
            oneSecPulse = 1'b1;
            cycle();
            oneSecPulse = 1'b0;
            cycle();
            n_cmp++;
            if (pulse !== 4'b0000 || active !== m_active) begin
                n_mis++;
                $display("FAIL shrink.pre tick=%0d got p=%b a=%b want p=0000 a=%b",
                         k, pulse, active, m_active);
            end
        end
        set_period(3, 3);
        oneSecPulse = 1'b1;
        cycle();
        n_cmp++;
        if (pulse[3] !== 1'b1) begin
            n_mis++;
            $display("FAIL shrink.fire got=%b want=1", pulse[3]);
        end
        oneSecPulse = 1'b0;
        cycle();
        for (int k = 1; k <= 2; k++) begin
            oneSecPulse = 1'b1;
            cycle();
            oneSecPulse = 1'b0;
            cycle();
        end
        // Asynchronous reset between edges, with two ticks of progress pending.
        #2 resetN = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if (pulse !== 4'b0000 || active !== 4'b0000) begin
            n_mis++;
            $display("FAIL shrink.reset got p=%b a=%b want p=0000 a=0000", pulse, active);
        end
        #2 resetN = 1'b1;
        cycle();
        for (int k = 1; k <= 3; k++) begin
            oneSecPulse = 1'b1;
            cycle();
            n_cmp++;
            if (pulse[3] !== (k == 3) || pulse !== m_pulse) begin
                n_mis++;
                $display("FAIL shrink.recount tick=%0d got=%b want=%0d", k, pulse[3], k == 3);
            end
            oneSecPulse = 1'b0;
            cycle();
        end
    endtask

    task automatic test_random();
        clear_all();
        for (int i = 0; i < 600; i++) begin
            if (i % 30 == 0) begin
                for (int c = 0; c < NCH; c++) begin
                    chan_en[c]  = ($urandom_range(0, 5) != 0);
                    one_shot[c] = $urandom_range(0, 1);
                    set_period(c, ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 5));
                end
            end
            if (i % 30 == 17) set_period($urandom_range(0, NCH - 1), $urandom_range(1, 3));
            oneSecPulse = ($urandom_range(0, 9) < 5);
            pause       = ($urandom_range(0, 7) == 0);
            for (int c = 0; c < NCH; c++) restart[c] = ($urandom_range(0, 24) == 0);
            cycle();
            n_cmp++;
            if (pulse !== m_pulse || active !== m_active) begin
                n_mis++;
                $display("FAIL random.cycle i=%0d got p=%b a=%b want p=%b a=%b",
                         i, pulse, active, m_pulse, m_active);
            end
        end
        restart     = '0;
        pause       = 1'b0;
        oneSecPulse = 1'b0;
    endtask

    initial begin
        n_cmp       = 0;
        n_mis       = 0;
        resetN      = 1'b0;
        oneSecPulse = 1'b0;
        pause       = 1'b0;
        chan_en     = '0;
        restart     = '0;
        one_shot    = '0;
        period      = '0;
        model_reset();
        #2;
        test_reset();
        test_periodic();
        test_one_shot();
        test_pause();
        test_restart_vs_tick();
        test_shrink_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/spawn_pulse_scheduler.md
SPAWN_PULSE_SCHEDULER -- requirements
Module: spawn_pulse_scheduler

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent pulse channels.
REQ-002 SHALL have parameter CNT_W, default 6, width of each channel's period and counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port resetN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port oneSecPulse  input  1  one-cycle time-base tick.
REQ-006 SHALL have port pause  input  1  global freeze; ticks ignored while high.
REQ-007 SHALL have port chan_en  input  NUM_CH  per-channel enable.
REQ-008 SHALL have port restart  input  NUM_CH  per-channel one-cycle counter restart.
REQ-009 SHALL have port one_shot  input  NUM_CH  per-channel mode: 1 = one-shot, 0 = periodic.
REQ-010 SHALL have port period  input  NUM_CH x CNT_W  per-channel period in ticks; 0 means channel inactive.
REQ-011 SHALL have port pulse  output  NUM_CH  per-channel one-cycle fire pulse, registered.
REQ-012 SHALL have port active  output  NUM_CH  high while channel is in COUNT state.

Function
REQ-013 Each channel SHALL implement states IDLE, COUNT and DONE, with a CNT_W-bit counter cnt.
REQ-014 IDLE -> COUNT SHALL occur when chan_en=1 and period!=0; cnt SHALL be 0 on entry.
REQ-015 Any state -> IDLE SHALL occur on the cycle after chan_en=0 or period=0 is sampled; cnt SHALL clear and pulse SHALL stay 0.
REQ-016 In COUNT, a sampled oneSecPulse with pause=0 SHALL increment cnt by 1.
REQ-017 Fire condition: in COUNT, tick with pause=0 and cnt >= period-1.
REQ-018 When the fire condition holds, pulse SHALL be high for exactly the cycle after the tick cycle (latency 1) and cnt SHALL return to 0.
REQ-019 After firing, periodic channels SHALL stay in COUNT; one-shot channels SHALL go to DONE.
REQ-020 DONE SHALL hold cnt at 0 and emit no pulse until restart or a chan_en drop.
REQ-021 restart SHALL clear cnt and enter COUNT (if enabled, period!=0) from any state, with priority over a simultaneous tick; no pulse results from that cycle.
REQ-022 If period is lowered to <= cnt mid-count, the channel SHALL fire on the next qualifying tick (the >= rule); no wrap-around past 2^CNT_W.
REQ-023 With period=1, a periodic channel SHALL fire on every unpaused tick.
REQ-024 While pause=1, cnt, state and pulse SHALL be frozen, except that restart and chan_en still act.
REQ-025 Channels SHALL be fully independent; simultaneous fires on several channels SHALL all assert in the same cycle.
REQ-026 A tick lasting more than one cycle SHALL advance cnt once per high cycle (no internal edge detection).

Reset
REQ-027 While resetN=0, every channel SHALL be in IDLE, with cnt=0, pulse=0 and active=0.
REQ-028 Reset asserted mid-count SHALL discard progress; after release, the channel SHALL re-enter COUNT from cnt=0 per REQ-014.

Structure
REQ-029 A shared package pulse_sched_pkg SHALL hold the channel state enum (IDLE, COUNT, DONE) and the default NUM_CH and CNT_W constants.
REQ-030 Per-channel logic SHALL be a sub-module, pulse_sched_channel, instantiated NUM_CH times by a generate loop; the top level only fans signals out.

Verification
REQ-031 Periodic: ch0 period=2, enabled, 6 ticks -> pulse[0] high the cycle after ticks 2, 4 and 6 only.
REQ-032 One-shot: ch1 period=3, one_shot=1, 9 ticks -> single pulse after tick 3 and active[1]=0 afterwards; restart then 3 ticks -> second pulse.
REQ-033 Pause: ch0 period=4; 2 ticks, pause=1 with 5 ticks, pause=0 with 2 ticks -> one pulse, after the final tick.
REQ-034 Restart vs. tick: ch2 period=2, cnt=1, restart and tick in the same cycle -> no pulse, cnt=0; next 2 ticks -> pulse.
REQ-035 Period shrink and reset: ch3 period=8, 5 ticks, then period=3 -> pulse after the next tick; resetN low mid-count -> all outputs 0 and cnt restarts from 0.
